// File: rtl/multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_main_fsm
//   Main control FSM for a multicycle RV32I core. Each instruction is stepped
//   through the shared ALU, the single memory port and the register file. The
//   FSM also drives ALUOp to the ALU decoder, plus the mux selects and write
//   enables for PC, IR, memory and register file. Supported instructions are
//   lw, sw, R-type, I-type ALU, beq and jal. Any other opcode seen in Decode
//   raises a one-cycle IllegalOp pulse and returns to Fetch.
//   Fetch, MemRead and MemWrite can stall on a memory-ready handshake.
//
// Parameters
//   USE_MEM_READY  1: Fetch/MemRead/MemWrite wait for MemReady=1
//                  0: MemReady is ignored (single-cycle memory)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; forces FETCH and zeroes outputs
//   op         in   instr[6:0] from the IR (valid from Decode onward)
//   Zero       in   ALU zero flag, qualifies the beq branch
//   MemReady   in   memory completes the current access this cycle
//   PCWrite    out  PC enable (PCUpdate | Branch & Zero)
//   AdrSrc     out  memory address select: 0=PC, 1=ALUOut
//   MemWrite   out  data memory write strobe
//   IRWrite    out  instruction register / OldPC enable
//   ResultSrc  out  00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA    out  00=PC, 01=OldPC, 10=RD1
//   ALUSrcB    out  00=RD2, 01=ImmExt, 10=const 4
//   ALUOp      out  00 add, 01 sub (branch), 10 funct-decoded
//   RegWrite   out  register file write enable
//   IllegalOp  out  one-cycle pulse for an undefined opcode in Decode
//   State      out  current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_main_fsm #(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_e;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_e state_q, state_d;
   logic   rdy;
   logic   pc_update;
   logic   branch;

   // With the handshake disabled every access completes in one cycle.
   assign rdy = USE_MEM_READY ? MemReady : 1'b1;

   // ---------------- state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   // NOTE: every always_comb output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_d = FETCH;  // also the recovery target for encodings 11-15
      case (state_q)
         FETCH:    state_d = rdy ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECR;
               OP_I:         state_d = EXECI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  state_d = rdy ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = rdy ? FETCH : MEMWRITE;
         EXECR:    state_d = ALUWB;
         EXECI:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BEQ:      state_d = FETCH;
         JAL:      state_d = ALUWB;
         default:  state_d = FETCH;
      endcase
   end

   // ---------------- output logic ----------------
   // Outputs are forced low while reset is high, so a write in flight is
   // dropped immediately instead of on the next edge.
   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               // During a stall only the enables drop; the selects stay put.
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = rdy;
               pc_update = rdy;
            end
            DECODE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b01;
               case (op)
                  OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: IllegalOp = 1'b0;
                  default:                                 IllegalOp = 1'b1;
               endcase
            end
            MEMADR: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
               ResultSrc = 2'b01;
               RegWrite  = 1'b1;
            end
            MEMWRITE: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            EXECR: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b10;
            end
            EXECI: begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               ALUOp   = 2'b10;
            end
            ALUWB:    RegWrite = 1'b1;
            BEQ: begin
               ALUSrcA = 2'b10;
               ALUOp   = 2'b01;
               branch  = 1'b1;
            end
            JAL: begin
               ALUSrcA   = 2'b01;
               ALUSrcB   = 2'b10;
               pc_update = 1'b1;
            end
            default: ;  // unreachable encodings: all outputs stay 0
         endcase
      end
   end

   assign PCWrite = pc_update | (branch & Zero);
   assign State   = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_fsm
//   Each scenario queues the expected per-cycle outputs together with the
//   MemReady/Zero stimulus for that cycle. The queue is then drained one clock
//   at a time, and the expected outputs are compared with the DUT on the
//   falling edge. A second instance with the handshake disabled runs a load
//   with MemReady held low.
// ---------------------------------------------------------------------------
module tb_multicycle_main_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, Zero, MemReady;
   logic [6:0] op;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [3:0] State;

   multicycle_main_fsm #(.USE_MEM_READY(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
      .IllegalOp(IllegalOp), .State(State)
   );

   // Instance with the handshake disabled and MemReady tied low.
   logic       reset_nr;
   logic [6:0] op_nr;
   logic       mr_nr = 1'b0;
   logic       pcw_nr, adr_nr, mw_nr, irw_nr, rw_nr, ill_nr;
   logic [1:0] rs_nr, sa_nr, sb_nr, aop_nr;
   logic [3:0] state_nr;

   multicycle_main_fsm #(.USE_MEM_READY(1'b0)) dut_nr (
      .clk(clk), .reset(reset_nr), .op(op_nr), .Zero(1'b0), .MemReady(mr_nr),
      .PCWrite(pcw_nr), .AdrSrc(adr_nr), .MemWrite(mw_nr),
      .IRWrite(irw_nr), .ResultSrc(rs_nr), .ALUSrcA(sa_nr),
      .ALUSrcB(sb_nr), .ALUOp(aop_nr), .RegWrite(rw_nr),
      .IllegalOp(ill_nr), .State(state_nr)
   );

   typedef struct packed {
      logic [3:0] state;
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       regwrite;
      logic       illegal;
   } out_t;

   typedef struct {
      logic mr;
      logic z;
      out_t exp;
   } item_t;

   out_t  obs;
   item_t sb[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   assign obs = '{state: State, pcwrite: PCWrite, adrsrc: AdrSrc,
                  memwrite: MemWrite, irwrite: IRWrite, resultsrc: ResultSrc,
                  alusrca: ALUSrcA, alusrcb: ALUSrcB, aluop: ALUOp,
                  regwrite: RegWrite, illegal: IllegalOp};

   // Expected outputs from the state table of the control specification.
   function automatic out_t exp_out(logic [3:0] st, logic rdy, logic z, logic ill);
      out_t e = '0;
      e.state = st;
      case (st)
         4'd0:  begin e.alusrcb = 2'b10; e.resultsrc = 2'b10;
                      e.irwrite = rdy; e.pcwrite = rdy; end
         4'd1:  begin e.alusrca = 2'b01; e.alusrcb = 2'b01; e.illegal = ill; end
         4'd2:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
         4'd3:  begin e.adrsrc = 1'b1; end
         4'd4:  begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
         4'd5:  begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
         4'd6:  begin e.alusrca = 2'b10; e.aluop = 2'b10; end
         4'd7:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 2'b10; end
         4'd8:  begin e.regwrite = 1'b1; end
         4'd9:  begin e.alusrca = 2'b10; e.aluop = 2'b01; e.pcwrite = z; end
         4'd10: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic push(input logic [3:0] st, input logic mr = 1'b1,
                       input logic z = 1'b0, input logic ill = 1'b0);
      item_t it;
      it.mr  = mr;
      it.z   = z;
      it.exp = exp_out(st, mr, z, ill);
      sb.push_back(it);
   endtask

   // Applies queued stimulus one cycle at a time and compares mid-cycle.
   task automatic drain(input string name);
      int step = 0;
      while (sb.size() > 0) begin
         item_t it;
         it = sb.pop_front();
         MemReady = it.mr;
         Zero     = it.z;
         @(negedge clk);
         n_checks++;
         if (obs !== it.exp)
            $display("FAIL %s step %0d: state=%0d outputs=%h, expected state=%0d outputs=%h",
                     name, step, obs.state, obs, it.exp.state, it.exp);
         else
            n_pass++;
         @(posedge clk);
         #1;
         step++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 7'd0; Zero = 1'b0; MemReady = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (obs !== '0) $display("FAIL reset: outputs=%h expected 0", obs);
      else n_pass++;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      op = OP_SW;
      push(4'd0); push(4'd1); push(4'd2);
      push(4'd5, 1'b0); push(4'd5, 1'b0);
      drain("sw_stall");
      // Still in MEMWRITE with the store pending; reset for two cycles.
      reset = 1'b1; MemReady = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== out_t'({4'd5, 14'd0}))
         $display("FAIL reset_mid_write first cycle: outputs=%h expected %h",
                  obs, out_t'({4'd5, 14'd0}));
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (obs !== '0) $display("FAIL reset_mid_write second cycle: outputs=%h expected 0", obs);
      else n_pass++;
      @(posedge clk);
      #1 reset = 1'b0; MemReady = 1'b1;
   endtask

   task automatic test_lw();
      op = OP_LW;
      push(4'd0); push(4'd1); push(4'd2); push(4'd3); push(4'd4);
      drain("lw");
   endtask

   task automatic test_lw_read_stall();
      op = OP_LW;
      push(4'd0); push(4'd1); push(4'd2);
      push(4'd3, 1'b0); push(4'd3, 1'b0); push(4'd3, 1'b1); push(4'd4);
      drain("lw_stall");
   endtask

   task automatic test_sw();
      op = OP_SW;
      push(4'd0); push(4'd1); push(4'd2); push(4'd5, 1'b1);
      drain("sw");
   endtask

   task automatic test_fetch_stall_add();
      op = OP_R;
      push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b0); push(4'd0, 1'b1);
      push(4'd1); push(4'd6); push(4'd8);
      drain("add_fetch_stall");
   endtask

   task automatic test_itype();
      op = OP_I;
      push(4'd0); push(4'd1); push(4'd7); push(4'd8);
      drain("addi");
   endtask

   task automatic test_beq();
      op = OP_BEQ;
      push(4'd0); push(4'd1); push(4'd9, 1'b1, 1'b1);
      push(4'd0); push(4'd1); push(4'd9, 1'b1, 1'b0);
      drain("beq");
   endtask

   task automatic test_illegal();
      op = 7'b0000000;
      push(4'd0); push(4'd1, 1'b1, 1'b0, 1'b1);
      drain("illegal_zero");
      op = 7'b1111111;
      push(4'd0); push(4'd1, 1'b1, 1'b0, 1'b1);
      drain("illegal_ones");
   endtask

   task automatic test_jal();
      op = OP_JAL;
      push(4'd0); push(4'd1); push(4'd10); push(4'd8); push(4'd0);
      drain("jal");
   endtask

   task automatic test_no_ready();
      logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      op_nr = OP_LW;
      @(posedge clk);
      #1 reset_nr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (state_nr !== exp_st[i] || rw_nr !== (i == 4))
            $display("FAIL no_ready step %0d: state=%0d regwrite=%b, expected state=%0d regwrite=%b",
                     i, state_nr, rw_nr, exp_st[i], (i == 4));
         else
            n_pass++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset_nr = 1'b1;
      op_nr    = 7'd0;
      test_reset();
      test_reset_mid_write();
      test_lw();
      test_lw_read_stall();
      test_sw();
      test_fetch_stall_add();
      test_itype();
      test_beq();
      test_illegal();
      test_jal();
      test_no_ready();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
